dma_bus_arbiter: RTL and testbench

//  CPU-side responder for the cycle-stealing DMA engine.
//  - Turns a device-ready request into a DMA cmd and answers the DMA bus request (BR) with a bus grant (BG).
//  - While BG is high, stalls CPU data-memory accesses.
//  - At DMA block boundaries, hands the bus back to the CPU so the CPU can steal cycles.
//  - Reports DMA completion to the CPU.

---
 rtl/dma_bus_arbiter_if.sv | 36 +++
 rtl/dma_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_dma_bus_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dma_bus_arbiter_if.sv
// Bus bundle between the CPU-side DMA responder and its surroundings.
//   slave  : the arbiter side (takes requests/strobes, drives cmd/BG/status)
//   master : the environment side (device, DMA engine, CPU)
// Signals:
//   dev_req       device has data ready
//   BR            bus request from the DMA engine
//   dma_wr        DMA memory-write strobe (falling edge under BG = block done)
//   dma_interrupt DMA end-of-transfer
//   cpu_mem_req   CPU wants a data-memory access this cycle
//   cmd           DMA command to the engine
//   BG            bus grant to the DMA engine
//   cpu_stall     CPU data access stalled (cpu_mem_req & BG)
//   dma_busy      transfer in progress
//   dma_done      one-cycle completion pulse
interface dma_bus_arbiter_if;
    logic dev_req;
    logic BR;
    logic dma_wr;
    logic dma_interrupt;
    logic cpu_mem_req;
    logic cmd;
    logic BG;
    logic cpu_stall;
    logic dma_busy;
    logic dma_done;

    modport slave (
        input  dev_req, BR, dma_wr, dma_interrupt, cpu_mem_req,
        output cmd, BG, cpu_stall, dma_busy, dma_done
    );

    modport master (
        output dev_req, BR, dma_wr, dma_interrupt, cpu_mem_req,
        input  cmd, BG, cpu_stall, dma_busy, dma_done
    );
endinterface

// File: rtl/dma_bus_arbiter.sv
// CPU-side responder for a cycle-stealing DMA engine.
// Turns a device request into a DMA command, grants the bus on BR, stalls
// CPU data accesses while the bus is granted, lets the CPU steal the bus at
// block boundaries (bounded by STEAL_MAX cycles) and reports completion.
// Ports:
//   CLK    clock, all state changes on posedge
//   reset  synchronous, active-high
//   bus    dma_bus_arbiter_if.slave (requests in; cmd/BG/status out)
module dma_bus_arbiter #(
    parameter int unsigned DMA_BLOCKS = 3,
    parameter int unsigned STEAL_MAX  = 4
) (
    input  logic             CLK,
    input  logic             reset,
    dma_bus_arbiter_if.slave bus
);
    localparam int unsigned     SW         = (STEAL_MAX > 1) ? $clog2(STEAL_MAX) : 1;
    localparam logic [1:0]      BLK_LAST   = 2'(DMA_BLOCKS);
    localparam logic [SW-1:0]   STEAL_LAST = SW'(STEAL_MAX - 1);

    typedef enum logic [2:0] {IDLE, CMD, GRANT, STEAL, DONE} state_t;

    state_t        state_q;
    logic          cmd_q;
    logic          bg_q;
    logic          busy_q;
    logic          done_q;
    logic          pending_q;
    logic          wr_q;
    logic [1:0]    blk_cnt_q;
    logic [SW-1:0] steal_cnt_q;

    logic          wr_in;
    logic          blk_edge;
    logic [2:0]    blk_inc;
    logic          steal_ok;

    // X/Z on the strobe resolves to 0 rather than propagating.
    always_comb begin
        wr_in = 1'b0;
        if (bus.dma_wr) wr_in = 1'b1;
    end

    assign blk_edge = bg_q & wr_q & ~wr_in;
    assign blk_inc  = {1'b0, blk_cnt_q} + 3'd1;
    // No steal at the last boundary: the transfer is about to finish anyway.
    assign steal_ok = bus.cpu_mem_req & (blk_inc < 3'(DMA_BLOCKS));

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_q       <= 1'b0;
            bg_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pending_q   <= 1'b0;
            wr_q        <= 1'b0;
            blk_cnt_q   <= '0;
            steal_cnt_q <= '0;
        end else begin
            wr_q   <= wr_in;
            done_q <= 1'b0;
            if (bus.dev_req && state_q != IDLE) pending_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (bus.dev_req || pending_q) begin
                        state_q   <= CMD;
                        cmd_q     <= 1'b1;
                        busy_q    <= 1'b1;
                        pending_q <= 1'b0;
                    end
                end
                CMD: begin
                    // CPU keeps priority until the first grant.
                    if (bus.BR && !bus.cpu_mem_req) begin
                        state_q <= GRANT;
                        bg_q    <= 1'b1;
                    end
                end
                GRANT: begin
                    if (bus.dma_interrupt) begin
                        state_q   <= DONE;
                        bg_q      <= 1'b0;
                        cmd_q     <= 1'b0;
                        done_q    <= 1'b1;
                        blk_cnt_q <= '0;
                    end else if (blk_edge) begin
                        if (blk_cnt_q != BLK_LAST) blk_cnt_q <= blk_cnt_q + 2'd1;
                        if (steal_ok) begin
                            state_q     <= STEAL;
                            bg_q        <= 1'b0;
                            steal_cnt_q <= '0;
                        end
                    end
                end
                STEAL: begin
                    if (steal_cnt_q != STEAL_LAST) steal_cnt_q <= steal_cnt_q + SW'(1);
                    if ((!bus.cpu_mem_req || steal_cnt_q == STEAL_LAST) && bus.BR) begin
                        state_q <= GRANT;
                        bg_q    <= 1'b1;
                    end
                end
                DONE: begin
                    // A request that arrived mid-transfer restarts without passing IDLE.
                    if (pending_q) begin
                        state_q   <= CMD;
                        cmd_q     <= 1'b1;
                        pending_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cmd_q   <= 1'b0;
                    bg_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd       = cmd_q;
    assign bus.BG        = bg_q;
    assign bus.dma_busy  = busy_q;
    assign bus.dma_done  = done_q;
    assign bus.cpu_stall = bus.cpu_mem_req & bg_q;
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter. Each scenario is a table of rows
// {reset, dev_req, BR, dma_wr, dma_interrupt, cpu_mem_req, BG, cmd, dma_busy,
// dma_done, cpu_stall}: the inputs are driven just after a posedge, the
// expected outputs are queued, and after the next posedge they are popped and
// compared against the DUT.
module tb_dma_bus_arbiter;
    logic CLK = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [4:0] sb[$];

    dma_bus_arbiter_if bus();

    dma_bus_arbiter #(.DMA_BLOCKS(3), .STEAL_MAX(4)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [10:0] r);
        reset             = r[10];
        bus.dev_req       = r[9];
        bus.BR            = r[8];
        bus.dma_wr        = r[7];
        bus.dma_interrupt = r[6];
        bus.cpu_mem_req   = r[5];
        sb.push_back(r[4:0]);
    endtask

    task automatic test_reset();
        logic [10:0] rows[$];
        logic [4:0]  got, exp;
        rows = '{11'b1_11000_00000, 11'b1_10000_00000, 11'b0_00000_00000};
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            exp = sb.pop_front();
            got = {bus.BG, bus.cmd, bus.dma_busy, bus.dma_done, bus.cpu_stall};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset row %0d: BG/cmd/busy/done/stall got %b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_plain();
        logic [10:0] rows[$];
        logic [4:0]  got, exp;
        rows = '{11'b0_00000_00000, 11'b0_10000_01100, 11'b0_00000_01100,
                 11'b0_01001_01100, 11'b0_01000_11100, 11'b0_01100_11100,
                 11'b0_01000_11100, 11'b0_01100_11100, 11'b0_01000_11100,
                 11'b0_01100_11100, 11'b0_01000_11100, 11'b0_00010_00110,
                 11'b0_00000_00000, 11'b0_00000_00000};
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            exp = sb.pop_front();
            got = {bus.BG, bus.cmd, bus.dma_busy, bus.dma_done, bus.cpu_stall};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL plain row %0d: BG/cmd/busy/done/stall got %b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_steal();
        logic [10:0] rows[$];
        logic [4:0]  got, exp;
        rows = '{11'b0_10000_01100, 11'b0_01000_11100, 11'b0_01100_11100,
                 11'b0_01001_01100, 11'b0_01001_01100, 11'b0_01001_01100,
                 11'b0_01000_11100, 11'b0_01100_11100, 11'b0_01000_11100,
                 11'b0_01100_11100, 11'b0_01001_11101, 11'b0_00010_00110,
                 11'b0_00000_00000};
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            exp = sb.pop_front();
            got = {bus.BG, bus.cmd, bus.dma_busy, bus.dma_done, bus.cpu_stall};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL steal row %0d: BG/cmd/busy/done/stall got %b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_steal_cap();
        logic [10:0] rows[$];
        logic [4:0]  got, exp;
        rows = '{11'b0_10000_01100, 11'b0_01000_11100, 11'b0_01100_11100,
                 11'b0_01001_01100, 11'b0_01001_01100, 11'b0_01001_01100,
                 11'b0_01001_01100, 11'b0_01001_11101, 11'b0_01001_11101,
                 11'b0_01101_11101, 11'b0_00001_01100, 11'b0_00001_01100,
                 11'b0_00001_01100, 11'b0_00001_01100, 11'b0_00001_01100,
                 11'b0_01001_11101, 11'b0_00010_00110, 11'b0_00000_00000};
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            exp = sb.pop_front();
            got = {bus.BG, bus.cmd, bus.dma_busy, bus.dma_done, bus.cpu_stall};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL steal_cap row %0d: BG/cmd/busy/done/stall got %b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_last_block();
        logic [10:0] rows[$];
        logic [4:0]  got, exp;
        rows = '{11'b0_10000_01100, 11'b0_01000_11100, 11'b0_01100_11100,
                 11'b0_01000_11100, 11'b0_01100_11100, 11'b0_01000_11100,
                 11'b0_01100_11100, 11'b0_01001_11101, 11'b0_01001_11101,
                 11'b0_01101_11101, 11'b0_01011_00110, 11'b0_00000_00000};
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            exp = sb.pop_front();
            got = {bus.BG, bus.cmd, bus.dma_busy, bus.dma_done, bus.cpu_stall};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL last_block row %0d: BG/cmd/busy/done/stall got %b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_pending();
        logic [10:0] rows[$];
        logic [4:0]  got, exp;
        rows = '{11'b0_10000_01100, 11'b0_01000_11100, 11'b0_11000_11100,
                 11'b0_01000_11100, 11'b0_00010_00110, 11'b0_00000_01100,
                 11'b0_01000_11100, 11'b0_00010_00110, 11'b0_00000_00000,
                 11'b0_00000_00000};
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            exp = sb.pop_front();
            got = {bus.BG, bus.cmd, bus.dma_busy, bus.dma_done, bus.cpu_stall};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pending row %0d: BG/cmd/busy/done/stall got %b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] rows[$];
        logic [4:0]  got, exp;
        rows = '{11'b0_10000_01100, 11'b0_01000_11100, 11'b0_11000_11100,
                 11'b0_01100_11100, 11'b1_01000_00000, 11'b0_00000_00000,
                 11'b0_00000_00000, 11'b0_10000_01100, 11'b0_01000_11100,
                 11'b0_01100_11100, 11'b0_01000_11100, 11'b0_00010_00110,
                 11'b0_00000_00000};
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            exp = sb.pop_front();
            got = {bus.BG, bus.cmd, bus.dma_busy, bus.dma_done, bus.cpu_stall};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_mid row %0d: BG/cmd/busy/done/stall got %b expected %b", i, got, exp);
            end
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus.dev_req       = 1'b0;
        bus.BR            = 1'b0;
        bus.dma_wr        = 1'b0;
        bus.dma_interrupt = 1'b0;
        bus.cpu_mem_req   = 1'b0;
        test_reset();
        test_plain();
        test_steal();
        test_steal_cap();
        test_last_block();
        test_pending();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
